// File: rtl/seq_011_pattern_tx.sv
// seq_011_pattern_tx
// Serial transmit end of the "011" detector link. Accepts a WIDTH-bit word
// when idle and shifts it MSB-first onto X, holding each bit for DIV clocks.
// While shifting it counts the "011" patterns that occur inside the frame.
// The count gives the downstream Moore detector a reference value.
// X idles high. Every output is a register. Reset is synchronous and
// active-high.

module seq_011_pattern_tx #(
  parameter int WIDTH = 8,  // frame length in bits, >= 3
  parameter int DIV   = 1,  // clocks per bit, >= 1
  parameter int CNT_W = 4   // Match_Cnt width, 2**CNT_W > WIDTH/3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic             Ready,
  output logic             X,
  output logic             Bit_Valid,
  output logic             Done,
  output logic [CNT_W-1:0] Match_Cnt
);

  // Counter widths. A DIV of 1 still needs a 1-bit divider register.
  // The bit counter must be able to hold WIDTH after the last bit.
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [DIV_W-1:0]   div_cnt_q;
  logic [1:0]         hist_q;
  logic [CNT_W-1:0]   match_cnt_q;
  logic               ready_q;
  logic               x_q;
  logic               bit_valid_q;
  logic               done_q;

  // Next-bit values, used only at the end of a bit period.
  logic               cur_bit;
  logic               bit_end;
  logic               last_bit;
  logic [WIDTH-1:0]   shreg_d;
  logic [1:0]         hist_d;
  logic [CNT_W-1:0]   match_cnt_d;

  // Bit-end bookkeeping: pattern match, history and shift for the bit on X.
  // NOTE: every always_comb output gets a default at the top, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    cur_bit     = shreg_q[WIDTH-1];
    bit_end     = (div_cnt_q == DIV_LAST);
    last_bit    = (bit_cnt_q == BIT_LAST);
    shreg_d     = shreg_q << 1;
    hist_d      = {hist_q[0], cur_bit};
    match_cnt_d = match_cnt_q;
    if ({hist_q, cur_bit} == 3'b011) begin
      match_cnt_d = match_cnt_q + CNT_W'(1);
    end
  end

  // Transmit FSM. State, datapath and the registered outputs are all here.
  // NOTE: state uses non-blocking assignments only. Every register then takes
  // its value from the pre-edge state, whatever the statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      hist_q      <= 2'b11;
      match_cnt_q <= '0;
      ready_q     <= 1'b1;
      x_q         <= 1'b1;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q     <= 1'b1;
          x_q         <= 1'b1;
          bit_valid_q <= 1'b0;
          done_q      <= 1'b0;
          if (Load) begin
            state_q     <= S_SHIFT;
            shreg_q     <= Din;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            hist_q      <= 2'b11;
            match_cnt_q <= '0;
            ready_q     <= 1'b0;
            // Present the MSB in the first cycle after acceptance.
            x_q         <= Din[WIDTH-1];
            bit_valid_q <= 1'b1;
          end
        end

        S_SHIFT: begin
          // Load is ignored here. The frame in progress is never disturbed.
          if (bit_end) begin
            match_cnt_q <= match_cnt_d;
            hist_q      <= hist_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_q + BIT_W'(1);
            div_cnt_q   <= '0;
            if (last_bit) begin
              state_q     <= S_DONE;
              x_q         <= 1'b1;
              bit_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              // The next bit is the one shifting into the MSB position.
              x_q <= shreg_q[WIDTH-2];
            end
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end

        S_DONE: begin
          // One-cycle completion pulse. Match_Cnt holds until the next Load.
          state_q     <= S_IDLE;
          done_q      <= 1'b0;
          ready_q     <= 1'b1;
          x_q         <= 1'b1;
          bit_valid_q <= 1'b0;
        end

        default: begin
          state_q     <= S_IDLE;
          ready_q     <= 1'b1;
          x_q         <= 1'b1;
          bit_valid_q <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign Ready     = ready_q;
  assign X         = x_q;
  assign Bit_Valid = bit_valid_q;
  assign Done      = done_q;
  assign Match_Cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_011_pattern_tx.sv
// Testbench for seq_011_pattern_tx.
// Two instances share the clock and reset: one with DIV=1 and one with DIV=3.
// A table of frames drives the DIV=1 instance. Hand-written sequences cover
// a held Load, the DIV=3 timing and a reset in the middle of a frame.

module tb_seq_011_pattern_tx;

  logic       clk;
  logic       rst;
  logic       load1, load3;
  logic [7:0] din1, din3;
  logic       ready1, x1, bv1, done1;
  logic       ready3, x3, bv3, done3;
  logic [3:0] cnt1, cnt3;

  int n_checks = 0;
  int n_pass   = 0;

  seq_011_pattern_tx #(.WIDTH(8), .DIV(1), .CNT_W(4)) dut1 (
    .Clk(clk), .Rst(rst), .Load(load1), .Din(din1),
    .Ready(ready1), .X(x1), .Bit_Valid(bv1), .Done(done1), .Match_Cnt(cnt1)
  );

  seq_011_pattern_tx #(.WIDTH(8), .DIV(3), .CNT_W(4)) dut3 (
    .Clk(clk), .Rst(rst), .Load(load3), .Din(din3),
    .Ready(ready3), .X(x3), .Bit_Valid(bv3), .Done(done3), .Match_Cnt(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stop the run if it ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [7:0] din;
    logic [3:0] exp_cnt;   // hand-counted "011" occurrences inside the frame
    int         inject_k;  // bit slot k in which a stray Load is pulsed, -1 = none
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to 1 ns after the next rising edge, so outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one frame on the DIV=1 instance and check every cycle of it.
  task automatic run_frame1(input vec_t v);
    logic [2:0] win;
    int         obs;
    win = 3'b000;
    obs = 0;
    load1 = 1'b1;
    din1  = v.din;
    tick();                      // now in cycle t+1
    load1 = 1'b0;
    din1  = 8'h00;
    for (int k = 0; k < 8; k++) begin
      check({v.name, " X bit"}, x1, v.din[7-k]);
      check({v.name, " Bit_Valid"}, bv1, 1'b1);
      check({v.name, " Ready busy"}, ready1, 1'b0);
      check({v.name, " no early Done"}, done1, 1'b0);
      win = {win[1:0], x1};
      if (k >= 2 && win == 3'b011) obs++;
      if (k == v.inject_k) begin
        load1 = 1'b1;
        din1  = 8'hAA;
      end
      tick();
      load1 = 1'b0;
      din1  = 8'h00;
    end
    // Cycle t+9: DONE
    check({v.name, " Done pulse"}, done1, 1'b1);
    check({v.name, " Match_Cnt"}, cnt1, v.exp_cnt);
    check({v.name, " X idle in DONE"}, x1, 1'b1);
    check({v.name, " Bit_Valid low in DONE"}, bv1, 1'b0);
    check({v.name, " Ready low in DONE"}, ready1, 1'b0);
    check({v.name, " in-frame pattern count"}, obs, 32'(v.exp_cnt));
    tick();
    // Cycle t+10: idle again
    check({v.name, " Ready after DONE"}, ready1, 1'b1);
    check({v.name, " Done cleared"}, done1, 1'b0);
    check({v.name, " Match_Cnt held"}, cnt1, v.exp_cnt);
  endtask

  initial begin
    logic [7:0] f;
    int         guard;
    bit         seen_done;

    vecs[0] = '{"t1_6C",      8'b0110_1100, 4'd2, -1};
    vecs[1] = '{"t2_FF",      8'hFF,        4'd0, -1};
    vecs[2] = '{"t2_00",      8'h00,        4'd0, -1};
    vecs[3] = '{"t3_5B",      8'b0101_1011, 4'd2, -1};
    vecs[4] = '{"t4_ignored", 8'b0110_1100, 4'd2,  2};  // stray Load in cycle t+3

    rst = 1'b1; load1 = 1'b0; load3 = 1'b0; din1 = 8'h00; din3 = 8'h00;
    tick();
    tick();
    check("reset Ready", ready1, 1'b1);
    check("reset X", x1, 1'b1);
    check("reset Bit_Valid", bv1, 1'b0);
    check("reset Done", done1, 1'b0);
    check("reset Match_Cnt", cnt1, 4'd0);
    check("reset Ready div3", ready3, 1'b1);
    rst = 1'b0;
    tick();

    // Table-driven frames on the DIV=1 instance
    for (int i = 0; i < 5; i++) begin
      run_frame1(vecs[i]);
    end

    // Load held high: frames run back to back. The DONE cycle and one idle
    // cycle come between them, with X=1 in both.
    load1 = 1'b1;
    din1  = 8'hF0;
    tick();
    for (int k = 0; k < 8; k++) begin
      check("held X bit", x1, (k < 4) ? 1'b1 : 1'b0);
      tick();
    end
    check("held DONE Done", done1, 1'b1);
    check("held DONE X", x1, 1'b1);
    tick();
    check("held gap Ready", ready1, 1'b1);
    check("held gap X", x1, 1'b1);
    check("held gap Bit_Valid", bv1, 1'b0);
    tick();
    check("held restart Bit_Valid", bv1, 1'b1);
    check("held restart X", x1, 1'b1);
    load1 = 1'b0;
    guard = 0;
    while (!ready1 && guard < 50) begin
      tick();
      guard++;
    end
    check("held drain within bound", guard < 50, 1'b1);
    tick();

    // DIV=3: each bit is held for three cycles, and Done comes in t+25
    load3 = 1'b1;
    din3  = 8'b0110_1100;
    tick();
    load3 = 1'b0;
    f = 8'b0110_1100;
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 3; r++) begin
        check("div3 X bit", x3, f[7-k]);
        check("div3 no early Done", done3, 1'b0);
        tick();
      end
    end
    check("div3 Done at t+25", done3, 1'b1);
    check("div3 Match_Cnt", cnt3, 4'd2);
    tick();
    check("div3 Ready at t+26", ready3, 1'b1);

    // Reset in the middle of a frame: the frame is aborted, with no Done pulse
    load1 = 1'b1;
    din1  = 8'b0110_1100;
    tick();                      // t+1
    load1 = 1'b0;
    tick();                      // t+2
    tick();                      // t+3
    tick();                      // t+4
    check("pre-reset in frame", bv1, 1'b1);
    rst = 1'b1;
    tick();                      // t+5
    rst = 1'b0;
    check("abort X", x1, 1'b1);
    check("abort Ready", ready1, 1'b1);
    check("abort Bit_Valid", bv1, 1'b0);
    check("abort Match_Cnt", cnt1, 4'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done1) seen_done = 1'b1;
      tick();
    end
    check("abort no Done pulse", seen_done, 1'b0);
    run_frame1(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
